// File: rtl/beta_imem_arbiter.sv
// ---------------------------------------------------------------------------
// beta_imem_arbiter
// Shares the single instruction-memory port between two requesters:
//   m0 = instruction fetch stage (can kill its in-flight response on flush)
//   m1 = secondary master (debug / boot loader / prefetch)
// One outstanding transaction at a time. Round-robin between the requesters:
// the side that did not own the last finished transaction wins a tie. A
// watchdog aborts a transaction that waits too long for its response.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   m0_req_i/m0_addr_i           fetch request + PC, held until m0_ready_o
//   m0_flush_i                   discard m0's in-flight response
//   m0_ready_o/m0_valid_o        accept pulse / response pulse for m0
//   m0_rdata_o                   response data (0 unless m0_valid_o)
//   m1_*                         same as m0, without flush
//   mem_req_o/mem_addr_o         request + latched address toward imem
//   mem_ready_i/mem_valid_i      imem accept / response strobes
//   mem_rdata_i                  imem response data
//   arb_owner_o                  current/last owner (0=m0, 1=m1)
//   arb_busy_o                   a transaction is in progress
//   arb_timeout_o                one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module beta_imem_arbiter #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_req_i,
  input  logic [DataWidth-1:0] m0_addr_i,
  input  logic                 m0_flush_i,
  output logic                 m0_ready_o,
  output logic                 m0_valid_o,
  output logic [DataWidth-1:0] m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic [DataWidth-1:0] m1_addr_i,
  output logic                 m1_ready_o,
  output logic                 m1_valid_o,
  output logic [DataWidth-1:0] m1_rdata_o,
  output logic                 mem_req_o,
  output logic [DataWidth-1:0] mem_addr_o,
  input  logic                 mem_ready_i,
  input  logic                 mem_valid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 arb_owner_o,
  output logic                 arb_busy_o,
  output logic                 arb_timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Watchdog fires when the counter reaches this value with no response.
  localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);
  localparam logic [15:0] CntMax  = 16'hFFFF;

  state_t               state_r, state_s;
  logic                 owner_r, owner_s;
  logic                 prio_r, prio_s;
  logic                 kill_r, kill_s;
  logic [15:0]          cnt_r, cnt_s;
  logic [DataWidth-1:0] addr_r, addr_s;

  logic grant_m1_s;
  logic flush_hit_s;
  logic accept_s;
  logic resp_s;
  logic expire_s;
  logic deliver_s;

  // Event decode shared by next-state and output logic.
  always_comb begin
    // On a tie the prio side wins; otherwise the lone requester wins.
    grant_m1_s  = (m0_req_i && m1_req_i) ? prio_r : m1_req_i;
    flush_hit_s = m0_flush_i && !owner_r && ((state_r == ISSUE) || (state_r == WAIT));
    accept_s    = (state_r == ISSUE) && mem_ready_i;
    resp_s      = (state_r == WAIT) && mem_valid_i;
    expire_s    = (state_r == WAIT) && !mem_valid_i && (cnt_r == CntLast);
    // A flush in the response cycle itself also suppresses the response.
    deliver_s   = resp_s && !kill_r && !flush_hit_s;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
      kill_r  <= 1'b0;
      cnt_r   <= 16'd0;
      addr_r  <= '0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      prio_r  <= prio_s;
      kill_r  <= kill_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    prio_s  = prio_r;
    kill_s  = kill_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_s = ISSUE;
          owner_s = grant_m1_s;
          addr_s  = grant_m1_s ? m1_addr_i : m0_addr_i;
          kill_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // Requester inputs are ignored here; only the flush can mark the
        // transaction, and the memory side still completes normally.
        kill_s = kill_r || flush_hit_s;
        if (mem_ready_i) begin
          state_s = WAIT;
          cnt_s   = 16'd0;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (mem_valid_i || (cnt_r == CntLast)) begin
          state_s = IDLE;
          prio_s  = ~owner_r;
          kill_s  = 1'b0;
        end else begin
          state_s = WAIT;
          kill_s  = kill_r || flush_hit_s;
          // Saturate rather than wrap so a runaway never re-arms silently.
          cnt_s   = (cnt_r != CntMax) ? (cnt_r + 16'd1) : cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        kill_s  = 1'b0;
      end
    endcase
  end

  // Output decode; ready/valid follow the memory strobes in the same cycle.
  always_comb begin
    mem_req_o     = (state_r == ISSUE);
    mem_addr_o    = addr_r;
    m0_ready_o    = accept_s && !owner_r;
    m1_ready_o    = accept_s && owner_r;
    m0_valid_o    = deliver_s && !owner_r;
    m1_valid_o    = deliver_s && owner_r;
    m0_rdata_o    = (deliver_s && !owner_r) ? mem_rdata_i : '0;
    m1_rdata_o    = (deliver_s && owner_r) ? mem_rdata_i : '0;
    arb_owner_o   = owner_r;
    arb_busy_o    = (state_r != IDLE);
    arb_timeout_o = expire_s;
  end

endmodule

// File: tb/tb_beta_imem_arbiter.sv
module tb_beta_imem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i, m0_flush_i, m1_req_i, mem_ready_i, mem_valid_i;
  logic [31:0] m0_addr_i, m1_addr_i, mem_rdata_i;
  logic        m0_ready_o, m0_valid_o, m1_ready_o, m1_valid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o;
  logic        mem_req_o, arb_owner_o, arb_busy_o, arb_timeout_o;

  beta_imem_arbiter #(.DataWidth(32), .TimeoutCycles(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_flush_i(m0_flush_i),
    .m0_ready_o(m0_ready_o), .m0_valid_o(m0_valid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
    .m1_ready_o(m1_ready_o), .m1_valid_o(m1_valid_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .arb_owner_o(arb_owner_o), .arb_busy_o(arb_busy_o), .arb_timeout_o(arb_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    bit          port;
    logic [31:0] data;
  } ev_t;

  ev_t grant_q[$];
  ev_t resp_q[$];
  ev_t tmo_q[$];
  int  cyc_n = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s cycle %0d: got an event, expected none", name, cyc_n);
  endtask

  task automatic missing(input string name, input int tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s cycle %0d: got nothing, expected event at cycle %0d", name, cyc_n, tag);
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic drive(input bit r0, input logic [31:0] a0, input bit fl,
                       input bit r1, input logic [31:0] a1,
                       input bit rdy, input bit vld, input logic [31:0] rd);
    @(negedge clk_i);
    cyc_n++;
    m0_req_i    = r0;
    m0_addr_i   = a0;
    m0_flush_i  = fl;
    m1_req_i    = r1;
    m1_addr_i   = a1;
    mem_ready_i = rdy;
    mem_valid_i = vld;
    mem_rdata_i = rd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push_ev(input int kind, input bit p, input logic [31:0] d);
    ev_t e;
    e.cyc  = cyc_n;
    e.port = p;
    e.data = d;
    if (kind == 0) grant_q.push_back(e);
    else if (kind == 1) resp_q.push_back(e);
    else tmo_q.push_back(e);
  endtask

  // Monitor: samples just before each rising edge and checks against queues.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk_i);
      #4;
      if (m0_ready_o || m1_ready_o) begin
        chk("ready_onehot", {31'b0, m0_ready_o & m1_ready_o}, 32'h0);
        if (grant_q.size() == 0) unexpected("ready");
        else begin
          e = grant_q.pop_front();
          chk("ready_cycle", cyc_n, e.cyc);
          chk("ready_port", {31'b0, m1_ready_o}, {31'b0, e.port});
          chk("mem_addr", mem_addr_o, e.data);
        end
      end
      while (grant_q.size() > 0 && grant_q[0].cyc <= cyc_n) begin
        missing("ready_missing", grant_q[0].cyc);
        void'(grant_q.pop_front());
      end
      if (m0_valid_o || m1_valid_o) begin
        chk("valid_onehot", {31'b0, m0_valid_o & m1_valid_o}, 32'h0);
        if (resp_q.size() == 0) unexpected("valid");
        else begin
          e = resp_q.pop_front();
          chk("valid_cycle", cyc_n, e.cyc);
          chk("valid_port", {31'b0, m1_valid_o}, {31'b0, e.port});
          chk("rdata", m1_valid_o ? m1_rdata_o : m0_rdata_o, e.data);
        end
      end
      while (resp_q.size() > 0 && resp_q[0].cyc <= cyc_n) begin
        missing("valid_missing", resp_q[0].cyc);
        void'(resp_q.pop_front());
      end
      if (arb_timeout_o) begin
        if (tmo_q.size() == 0) unexpected("timeout");
        else begin
          e = tmo_q.pop_front();
          chk("timeout_cycle", cyc_n, e.cyc);
        end
      end
      while (tmo_q.size() > 0 && tmo_q[0].cyc <= cyc_n) begin
        missing("timeout_missing", tmo_q[0].cyc);
        void'(tmo_q.pop_front());
      end
      if (!m0_valid_o) chk("m0_rdata_zero", m0_rdata_o, 32'h0);
      if (!m1_valid_o) chk("m1_rdata_zero", m1_rdata_o, 32'h0);
    end
  end

  initial begin : stimulus
    logic [31:0] a0v;
    logic [31:0] a1v;
    bit          p;
    m0_req_i = 1'b0; m0_addr_i = 32'h0; m0_flush_i = 1'b0;
    m1_req_i = 1'b0; m1_addr_i = 32'h0;
    mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset state
    idle();
    idle();
    #1;
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_busy", {31'b0, arb_busy_o}, 32'h0);
    chk("rst_owner", {31'b0, arb_owner_o}, 32'h0);
    chk("rst_timeout", {31'b0, arb_timeout_o}, 32'h0);
    rst_i = 1'b0;

    // T1: m0 alone, ready two cycles after request, valid one cycle later
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 chk("t1_req_c0", {31'b0, mem_req_o}, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 chk("t1_req_c1", {31'b0, mem_req_o}, 32'h1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b0, 32'h0);
    #1 chk("t1_req_c2", {31'b0, mem_req_o}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    push_ev(1, 1'b0, 32'h0000_0013);
    #1 chk("t1_req_c3", {31'b0, mem_req_o}, 32'h0);
    idle();
    #1 chk("t1_busy_after", {31'b0, arb_busy_o}, 32'h0);

    // T6: m1 alone, memory stalls ISSUE for 10 cycles; m0 input noise ignored
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000_0040, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b1, 32'h2000_0040, 1'b0, 1'b0, 32'h0);
      #1;
      chk("t6_mem_req", {31'b0, mem_req_o}, 32'h1);
      chk("t6_mem_addr", mem_addr_o, 32'h2000_0040);
      chk("t6_owner", {31'b0, arb_owner_o}, 32'h1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000_0040, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b1, 32'h2000_0040);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA);
    push_ev(1, 1'b1, 32'h5555_AAAA);
    idle();

    // T3: flush while m0 waits; then m1 wins; then same-cycle flush
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b0, 32'h200);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    #1 chk("t3_wait_no_req", {31'b0, mem_req_o}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 1'b0, 1'b1, 32'h0000_1234);
    #1 chk("t3_killed_valid", {31'b0, m0_valid_o}, 32'h0);
    drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b1, 32'h3000);
    drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001);
    push_ev(1, 1'b1, 32'hCAFE_0001);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b0, 32'h300);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0003);
    #1 chk("t3_flush_same_cycle", {31'b0, m0_valid_o}, 32'h0);
    idle();

    // T4: watchdog with TimeoutCycles=4, then a late response is ignored
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b0, 32'h400);
    idle();
    idle();
    idle();
    idle();
    push_ev(2, 1'b0, 32'h0);
    #1 chk("t4_busy_at_expiry", {31'b0, arb_busy_o}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_BEEF);
    #1 chk("t4_idle_after", {31'b0, arb_busy_o}, 32'h0);
    idle();

    // T5: asynchronous reset in the middle of an m1 WAIT
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
    push_ev(0, 1'b1, 32'h500);
    idle();
    #2 rst_i = 1'b1;
    #1;
    chk("t5_mem_addr", mem_addr_o, 32'h0);
    chk("t5_busy", {31'b0, arb_busy_o}, 32'h0);
    chk("t5_owner", {31'b0, arb_owner_o}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0077);
    #1 rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0077);
    idle();

    // T2: both request continuously; prio restarts at m0 after reset
    a0v = 32'h100;
    a1v = 32'h8000;
    for (int i = 0; i < 4; i++) begin
      p = (i % 2) == 1;
      drive(1'b1, a0v, 1'b0, 1'b1, a1v, 1'b0, 1'b0, 32'h0);
      drive(1'b1, a0v, 1'b0, 1'b1, a1v, 1'b1, 1'b0, 32'h0);
      push_ev(0, p, p ? a1v : a0v);
      if (p) a1v = a1v + 32'h4;
      else a0v = a0v + 32'h4;
      drive(1'b1, a0v, 1'b0, 1'b1, a1v, 1'b0, 1'b1, 32'hD000_0000 + 32'(i));
      push_ev(1, p, 32'hD000_0000 + 32'(i));
    end
    idle();
    idle();
    idle();

    chk("grant_q_drained", 32'(grant_q.size()), 32'h0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
    chk("tmo_q_drained", 32'(tmo_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
